kbd_fifo: RTL and testbench

Port-mapped keyboard buffer between the PS/2 receiver/AT→ASCII converter and the kr580 I/O port router. It filters protocol bytes, folds the F0 break prefix into bit 7 of the key code, and queues up to DEPTH codes so no keystroke is lost while the CPU is busy. It also drives the CPU interrupt request (`pin_intr`) whenever a key is waiting and interrupts are enabled.

---
 rtl/kbd_fifo_if.sv | 54 +++++
 rtl/kbd_fifo.sv | 176 +++++++++++++++++
 tb/tb_kbd_fifo.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/kbd_fifo_if.sv
// ----------------------------------------------------------------------------
// kbd_fifo_if
//
// Signal bundle between the keyboard front end (PS/2 receiver plus AT->ASCII
// converter), the CPU port router and the keyboard buffer.
//
//   ps2_data     raw received PS/2 byte
//   ps2_data_en  one-cycle strobe, ps2_data valid
//   ascii        converter output for the current ps2_data (same cycle)
//   pin_pa       CPU port address
//   pin_po       CPU port write data
//   pin_pw       CPU port write strobe, one cycle per OUT
//   kb_head      code at the buffer head, 8'h00 when empty (IN FE)
//   kb_status    {overflow, irq_en, 1'b0, count[4:0]} (IN FF)
//   pin_intr     registered interrupt request
//
// The master modport is the system side that feeds bytes and issues port
// writes; the slave modport is the keyboard buffer itself.
// ----------------------------------------------------------------------------
interface kbd_fifo_if;
    logic [7:0] ps2_data;
    logic       ps2_data_en;
    logic [7:0] ascii;
    logic [7:0] pin_pa;
    logic [7:0] pin_po;
    logic       pin_pw;
    logic [7:0] kb_head;
    logic [7:0] kb_status;
    logic       pin_intr;

    modport master (
        output ps2_data,
        output ps2_data_en,
        output ascii,
        output pin_pa,
        output pin_po,
        output pin_pw,
        input  kb_head,
        input  kb_status,
        input  pin_intr
    );

    modport slave (
        input  ps2_data,
        input  ps2_data_en,
        input  ascii,
        input  pin_pa,
        input  pin_po,
        input  pin_pw,
        output kb_head,
        output kb_status,
        output pin_intr
    );
endinterface

// File: rtl/kbd_fifo.sv
// ----------------------------------------------------------------------------
// kbd_fifo
//
// Port-mapped keyboard buffer. Protocol bytes from the PS/2 receiver are
// filtered, the F0 break prefix is folded into bit 7 of the following key
// code, and up to DEPTH codes are queued until the CPU reads them. An
// interrupt request is held high while a key is waiting and interrupts are
// enabled.
//
// Parameters:
//   DEPTH   number of buffer entries, power of two, 2..16
//   AW      pointer width, log2(DEPTH)
//
// Ports:
//   clk      CPU clock; every input in the bundle is synchronous to it
//   reset_n  asynchronous active-low reset
//   bus      kbd_fifo_if slave modport (PS/2 byte input, CPU port writes,
//            head/status read values, interrupt request)
//
// CPU port map:
//   IN  FE   kb_head
//   IN  FF   kb_status
//   OUT FF   bit 7 clears overflow, bit 6 flushes, any write pops one code
//   OUT FD   bit 0 sets the interrupt enable
// ----------------------------------------------------------------------------
module kbd_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    kbd_fifo_if.slave  bus
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          brk;
    logic          overflow;
    logic          irq_en;
    logic          intr_q;

    logic          is_break_prefix;
    logic          is_filtered;
    logic          produce;
    logic [7:0]    code;
    logic          ctrl_write;
    logic          irq_write;
    logic          empty;
    logic          full;
    logic          flush;
    logic          pop;
    logic          push;
    logic          overflow_set;
    logic          overflow_clr;
    logic          unused_po_bits;

    // Classify the incoming byte. F0 arms the break prefix, the listed
    // protocol/acknowledge bytes are thrown away, everything else is a key.
    always_comb begin
        is_break_prefix = 1'b0;
        is_filtered     = 1'b0;
        if (bus.ps2_data_en) begin
            case (bus.ps2_data)
                8'hF0:   is_break_prefix = 1'b1;
                8'hE0, 8'hFA, 8'hAA, 8'hEE,
                8'hFE, 8'h00, 8'hFF:
                         is_filtered = 1'b1;
                default: ;
            endcase
        end
    end

    assign produce = bus.ps2_data_en & ~is_break_prefix & ~is_filtered;

    // Converter codes in the E0..EF range are special keys that already carry
    // their own bit 7, so the break flag cannot be folded into them.
    assign code = (bus.ascii[7:4] == 4'hE) ? bus.ascii : {brk, bus.ascii[6:0]};

    assign ctrl_write = bus.pin_pw & (bus.pin_pa == 8'hFF);
    assign irq_write  = bus.pin_pw & (bus.pin_pa == 8'hFD);

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    // Flush overrides everything on the data path: no pop, no push and no
    // overflow report for a code arriving in the same cycle. A pop frees a
    // slot, so a full buffer still accepts a push in the same cycle.
    assign flush        = ctrl_write & bus.pin_po[6];
    assign pop          = ctrl_write & ~empty & ~flush;
    assign push         = produce & ~flush & (~full | pop);
    assign overflow_set = produce & ~flush & full & ~pop;
    assign overflow_clr = ctrl_write & bus.pin_po[7];

    assign unused_po_bits = &{1'b0, bus.pin_po[5:1]};

    // Storage is plain registers without reset; only the pointers decide
    // which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= code;
        end
    end

    // Pointers and occupancy. Pointers wrap naturally at AW bits, while count
    // carries one extra bit so that full and empty are distinguishable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The break prefix survives filtered bytes and is consumed by the next
    // produced code even if that code is dropped or flushed away.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            brk <= 1'b0;
        end else if (is_break_prefix) begin
            brk <= 1'b1;
        end else if (produce) begin
            brk <= 1'b0;
        end
    end

    // Sticky overflow; a new drop in the same cycle as a clear request wins
    // so that the CPU never misses a lost keystroke.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (overflow_set) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

    // Interrupt enable and the registered level-sensitive request. The
    // request follows count one cycle late, so it rises two cycles after a
    // strobe and falls one cycle after the buffer drains.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en <= 1'b0;
            intr_q <= 1'b0;
        end else begin
            if (irq_write) begin
                irq_en <= bus.pin_po[0];
            end
            intr_q <= irq_en & ~empty;
        end
    end

    assign bus.kb_head   = empty ? 8'h00 : mem[rd_ptr];
    assign bus.kb_status = {overflow, irq_en, 1'b0, 5'(count)};
    assign bus.pin_intr  = intr_q;

endmodule

// File: tb/tb_kbd_fifo.sv
// ----------------------------------------------------------------------------
// tb_kbd_fifo
//
// Self-checking bench for kbd_fifo (DEPTH=16). Expected key codes are pushed
// into a scoreboard queue as bytes are driven and compared against kb_head
// whenever the bench pops the buffer. A vector table covers the byte
// classification rules; hand-written sequences cover overflow, full-buffer
// push/pop, interrupt timing, flush and reset in the middle of a break prefix.
// ----------------------------------------------------------------------------
module tb_kbd_fifo;

    typedef struct {
        logic [7:0] data;
        logic [7:0] ascii;
        logic       has_code;
        logic [7:0] code;
        logic [7:0] exp_count;
    } vec_t;

    logic clk;
    logic reset_n;

    int checks;
    int errors;

    logic [7:0] sb [$];

    kbd_fifo_if bus ();

    kbd_fifo #(
        .DEPTH (16),
        .AW    (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running 100 MHz bench clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge, where inputs change and
    // outputs are sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %02h, expected %02h", name, actual, expected);
        end
    endtask

    // One PS/2 byte strobe.
    task automatic apply_stimulus(input logic [7:0] data, input logic [7:0] ascii);
        bus.ps2_data    = data;
        bus.ascii       = ascii;
        bus.ps2_data_en = 1'b1;
        tick();
        bus.ps2_data_en = 1'b0;
    endtask

    // One CPU OUT instruction.
    task automatic port_write(input logic [7:0] addr, input logic [7:0] data);
        bus.pin_pa = addr;
        bus.pin_po = data;
        bus.pin_pw = 1'b1;
        tick();
        bus.pin_pw = 1'b0;
    endtask

    // PS/2 strobe and OUT FF in the same cycle.
    task automatic push_with_ctrl(input logic [7:0] data, input logic [7:0] ascii, input logic [7:0] po);
        bus.ps2_data    = data;
        bus.ascii       = ascii;
        bus.ps2_data_en = 1'b1;
        bus.pin_pa      = 8'hFF;
        bus.pin_po      = po;
        bus.pin_pw      = 1'b1;
        tick();
        bus.ps2_data_en = 1'b0;
        bus.pin_pw      = 1'b0;
    endtask

    function automatic logic [7:0] sb_head();
        return (sb.size() != 0) ? sb[0] : 8'h00;
    endfunction

    task automatic check_output(input string name);
        check({name, "_count"}, {3'b000, bus.kb_status[4:0]}, 8'(sb.size()));
        check({name, "_head"}, bus.kb_head, sb_head());
    endtask

    // Compare the head with the oldest expected code, then pop it.
    task automatic pop_and_check(input logic [7:0] po);
        logic [7:0] discard;
        check("pop_head", bus.kb_head, sb_head());
        if (sb.size() != 0) begin
            discard = sb.pop_front();
        end
        port_write(8'hFF, po);
        check("pop_count", {3'b000, bus.kb_status[4:0]}, 8'(sb.size()));
    endtask

    vec_t vecs [17];

    initial begin
        logic [7:0] discard;

        checks = 0;
        errors = 0;

        vecs[0]  = '{8'h1C, 8'h61, 1'b1, 8'h61, 8'd1};
        vecs[1]  = '{8'hF0, 8'h00, 1'b0, 8'h00, 8'd1};
        vecs[2]  = '{8'h1C, 8'h61, 1'b1, 8'hE1, 8'd2};
        vecs[3]  = '{8'hE0, 8'h00, 1'b0, 8'h00, 8'd2};
        vecs[4]  = '{8'h75, 8'hE3, 1'b1, 8'hE3, 8'd3};
        vecs[5]  = '{8'hFA, 8'h00, 1'b0, 8'h00, 8'd3};
        vecs[6]  = '{8'hAA, 8'h00, 1'b0, 8'h00, 8'd3};
        vecs[7]  = '{8'hEE, 8'h55, 1'b0, 8'h00, 8'd3};
        vecs[8]  = '{8'hF0, 8'h00, 1'b0, 8'h00, 8'd3};
        vecs[9]  = '{8'hFE, 8'h00, 1'b0, 8'h00, 8'd3};
        vecs[10] = '{8'h00, 8'h00, 1'b0, 8'h00, 8'd3};
        vecs[11] = '{8'hFF, 8'h00, 1'b0, 8'h00, 8'd3};
        vecs[12] = '{8'hE0, 8'h00, 1'b0, 8'h00, 8'd3};
        vecs[13] = '{8'h74, 8'h72, 1'b1, 8'hF2, 8'd4};
        vecs[14] = '{8'hF0, 8'h00, 1'b0, 8'h00, 8'd4};
        vecs[15] = '{8'h6B, 8'hE5, 1'b1, 8'hE5, 8'd5};
        vecs[16] = '{8'h1C, 8'hC1, 1'b1, 8'h41, 8'd6};

        bus.ps2_data    = 8'h00;
        bus.ps2_data_en = 1'b0;
        bus.ascii       = 8'h00;
        bus.pin_pa      = 8'h00;
        bus.pin_po      = 8'h00;
        bus.pin_pw      = 1'b0;
        reset_n         = 1'b0;

        // Reset state.
        tick();
        tick();
        check("reset_status", bus.kb_status, 8'h00);
        check("reset_head", bus.kb_head, 8'h00);
        check("reset_intr", {7'b0, bus.pin_intr}, 8'h00);
        reset_n = 1'b1;
        tick();

        // Byte classification and break folding.
        $display("[TB] classification vectors");
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(vecs[i].data, vecs[i].ascii);
            if (vecs[i].has_code) begin
                sb.push_back(vecs[i].code);
            end
            check($sformatf("vec%0d_count", i), {3'b000, bus.kb_status[4:0]}, vecs[i].exp_count);
            check_output($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 8 && sb.size() != 0; i++) begin
            pop_and_check(8'h00);
        end
        check("drained_status", bus.kb_status, 8'h00);

        // Pop on empty is ignored.
        port_write(8'hFF, 8'h00);
        check("empty_pop_status", bus.kb_status, 8'h00);
        check("empty_pop_head", bus.kb_head, 8'h00);

        // Push and pop together on empty: only the push lands.
        push_with_ctrl(8'h1C, 8'h62, 8'h00);
        sb.push_back(8'h62);
        check_output("empty_pushpop");
        pop_and_check(8'h00);

        // Overflow: 17 codes into 16 slots, the last one is dropped.
        $display("[TB] overflow sequence");
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(8'h10 + 8'(i), 8'h30 + 8'(i));
            if (i < 16) begin
                sb.push_back(8'h30 + 8'(i));
            end
        end
        check("ovf_status", bus.kb_status, 8'h90);
        check("ovf_head", bus.kb_head, 8'h30);
        pop_and_check(8'h80);
        check("ovf_clear_status", bus.kb_status, 8'h0F);

        // Refill to full, then push and pop in the same cycle.
        apply_stimulus(8'h11, 8'h50);
        sb.push_back(8'h50);
        check("refill_status", bus.kb_status, 8'h10);
        check("full_pushpop_head", bus.kb_head, sb_head());
        discard = sb.pop_front();
        sb.push_back(8'h51);
        push_with_ctrl(8'h12, 8'h51, 8'h00);
        check("full_pushpop_status", bus.kb_status, 8'h10);
        for (int i = 0; i < 15; i++) begin
            pop_and_check(8'h00);
        end
        check("tail_head", bus.kb_head, 8'h51);
        check("tail_status", bus.kb_status, 8'h01);
        pop_and_check(8'h00);

        // Interrupt timing and flush.
        $display("[TB] interrupt and flush");
        port_write(8'hFD, 8'h01);
        check("irq_en_status", bus.kb_status, 8'h40);
        apply_stimulus(8'h1C, 8'h61);
        sb.push_back(8'h61);
        check("intr_n1", {7'b0, bus.pin_intr}, 8'h00);
        check("intr_n1_status", bus.kb_status, 8'h41);
        tick();
        check("intr_n2", {7'b0, bus.pin_intr}, 8'h01);
        port_write(8'hFF, 8'h40);
        sb.delete();
        check("flush_status", bus.kb_status, 8'h40);
        check("flush_head", bus.kb_head, 8'h00);
        check("flush_intr_held", {7'b0, bus.pin_intr}, 8'h01);
        tick();
        check("flush_intr_drop", {7'b0, bus.pin_intr}, 8'h00);

        // Flush beats a same-cycle push and does not report overflow.
        apply_stimulus(8'h1C, 8'h63);
        push_with_ctrl(8'h1D, 8'h64, 8'h40);
        check("flush_push_status", bus.kb_status, 8'h40);
        check("flush_push_head", bus.kb_head, 8'h00);

        // Reset in the middle of a break prefix.
        $display("[TB] reset mid-stream");
        apply_stimulus(8'h1C, 8'h61);
        apply_stimulus(8'hF0, 8'h00);
        tick();
        reset_n = 1'b0;
        #1;
        check("midrst_status", bus.kb_status, 8'h00);
        check("midrst_head", bus.kb_head, 8'h00);
        check("midrst_intr", {7'b0, bus.pin_intr}, 8'h00);
        tick();
        reset_n = 1'b1;
        apply_stimulus(8'h1C, 8'h61);
        check("postrst_head", bus.kb_head, 8'h61);
        check("postrst_status", bus.kb_status, 8'h01);
        tick();
        check("postrst_intr", {7'b0, bus.pin_intr}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
